// File: rtl/output_port_rr_sched.sv
// output_port_rr_sched: round-robin, credit-gated scheduler for one NoC router output link
module output_port_rr_sched #(
  parameter int WIDTH_packet = 57,
  parameter int CREDITS      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                in_valid,
  input  logic [4*WIDTH_packet-1:0] in_data,
  output logic [3:0]                in_ready,
  output logic                      out_valid,
  output logic [WIDTH_packet-1:0]   out_data,
  input  logic                      credit_return,
  output logic [3:0]                credit_cnt,
  output logic [1:0]                grant_id,
  output logic                      err_credit_ovf
);
  localparam logic [3:0] CMAX = 4'(CREDITS);
  logic [1:0] rr_ptr, g, idx;
  logic found, grant;
  always_comb begin
    g = rr_ptr;
    idx = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        g = idx;
        found = 1'b1;
      end
    end
  end
  // a same-cycle credit return never enables a grant: only the registered count is used
  assign grant = !rst && credit_cnt != 4'd0 && |in_valid;
  assign in_ready = grant ? 4'b0001 << g : 4'b0000;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      credit_cnt <= CMAX;
      rr_ptr <= 2'd0;
      grant_id <= 2'd0;
      err_credit_ovf <= 1'b0;
    end else begin
      out_valid <= grant;
      if (grant) begin
        out_data <= in_data[int'(g)*WIDTH_packet +: WIDTH_packet];
        grant_id <= g;
        rr_ptr <= g + 2'd1;
      end
      if (grant && !credit_return) credit_cnt <= credit_cnt - 4'd1;
      else if (!grant && credit_return) begin
        if (credit_cnt == CMAX) err_credit_ovf <= 1'b1;
        else credit_cnt <= credit_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_output_port_rr_sched.sv
// tb_output_port_rr_sched: directed vector table plus hand sequences for credit stall and overflow
module tb_output_port_rr_sched;
  localparam int W = 57;
  logic clk = 1'b0;
  logic rst, credit_return, out_valid, err_credit_ovf;
  logic [3:0] in_valid, in_ready, credit_cnt;
  logic [4*W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [1:0] grant_id;
  int errors = 0;
  int checks = 0;

  output_port_rr_sched #(.WIDTH_packet(W), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .credit_return(credit_return),
    .credit_cnt(credit_cnt), .grant_id(grant_id), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       cr;
    logic [W-1:0] base;
    logic [3:0] rdy;
    logic       ov;
    logic [W-1:0] od;
    logic [3:0] cnt;
    logic [1:0] gid;
    logic       ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic cr, input logic [W-1:0] base);
    rst = r;
    in_valid = v;
    credit_return = cr;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string n, input logic ov, input logic [W-1:0] od, input logic [3:0] cnt, input logic [1:0] gid, input logic ovf);
    chk({n, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({n, ".out_data"}, 64'(out_data), 64'(od));
    chk({n, ".credit_cnt"}, 64'(credit_cnt), 64'(cnt));
    chk({n, ".grant_id"}, 64'(grant_id), 64'(gid));
    chk({n, ".err_credit_ovf"}, 64'(err_credit_ovf), 64'(ovf));
  endtask

  initial begin
    drive(1'b1, 4'b0000, 1'b0, '0);
    // reset, including in_ready forced low while rst=1
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 57'h0,   4'b0000, 1'b0, 57'h0,   4'd4, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 57'h0,   4'b0000, 1'b0, 57'h0,   4'd4, 2'd0, 1'b0});
    // single requester 2 drains all credits
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 57'h1A9, 4'b0100, 1'b1, 57'h1AB, 4'd3, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 57'h1A9, 4'b0100, 1'b1, 57'h1AB, 4'd2, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 57'h1A9, 4'b0100, 1'b1, 57'h1AB, 4'd1, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 57'h1A9, 4'b0100, 1'b1, 57'h1AB, 4'd0, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 57'h1A9, 4'b0000, 1'b0, 57'h1AB, 4'd0, 2'd2, 1'b0});
    // reset reloads credits; then round robin with returns
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 57'h100, 4'b0000, 1'b0, 57'h0,   4'd4, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 57'h100, 4'b0001, 1'b1, 57'h100, 4'd3, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 57'h100, 4'b0010, 1'b1, 57'h101, 4'd3, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 57'h100, 4'b0100, 1'b1, 57'h102, 4'd3, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 57'h100, 4'b1000, 1'b1, 57'h103, 4'd3, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 57'h100, 4'b0001, 1'b1, 57'h100, 4'd3, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 57'h100, 4'b0010, 1'b1, 57'h101, 4'd3, 2'd1, 1'b0});
    // reset drops the in-flight pulse; then pointer to 3 and skip/wrap over 0110
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 57'h200, 4'b0000, 1'b0, 57'h0,   4'd4, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 57'h200, 4'b0100, 1'b1, 57'h202, 4'd3, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 1'b0, 57'h200, 4'b0010, 1'b1, 57'h201, 4'd2, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 1'b0, 57'h200, 4'b0100, 1'b1, 57'h202, 4'd1, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 1'b0, 57'h200, 4'b0010, 1'b1, 57'h201, 4'd0, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 1'b0, 57'h200, 4'b0000, 1'b0, 57'h201, 4'd0, 2'd1, 1'b0});
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].v, tbl[r].cr, tbl[r].base);
      #1;
      chk($sformatf("row%0d.in_ready", r), 64'(in_ready), 64'(tbl[r].rdy));
      tick();
      chk_regs($sformatf("row%0d", r), tbl[r].ov, tbl[r].od, tbl[r].cnt, tbl[r].gid, tbl[r].ovf);
    end
    // credit stall: cnt=0, return in cycle T, grant at T+1, out_valid at T+2
    drive(1'b0, 4'b0001, 1'b1, 57'h300);
    #1;
    chk("stall.ready_T", 64'(in_ready), 64'(4'b0000));
    tick();
    chk_regs("stall.T", 1'b0, 57'h201, 4'd1, 2'd1, 1'b0);
    drive(1'b0, 4'b0001, 1'b0, 57'h300);
    #1;
    chk("stall.ready_T1", 64'(in_ready), 64'(4'b0001));
    tick();
    chk_regs("stall.T1", 1'b1, 57'h300, 4'd0, 2'd0, 1'b0);
    #1;
    chk("stall.ready_T2", 64'(in_ready), 64'(4'b0000));
    // overflow: return at full credits sets the sticky flag
    drive(1'b1, 4'b0000, 1'b0, '0);
    tick();
    drive(1'b0, 4'b0000, 1'b1, '0);
    tick();
    chk_regs("ovf.set", 1'b0, 57'h0, 4'd4, 2'd0, 1'b1);
    drive(1'b0, 4'b1000, 1'b0, 57'h400);
    tick();
    chk_regs("ovf.hold", 1'b1, 57'h403, 4'd3, 2'd3, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, '0);
    tick();
    chk_regs("ovf.idle", 1'b0, 57'h403, 4'd3, 2'd3, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, '0);
    tick();
    chk_regs("ovf.clear", 1'b0, 57'h0, 4'd4, 2'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
